sub_16_serial: RTL and testbench
================================

Name: sub_16_serial

Overview:
Multi-cycle 16-bit subtractor computing diff = a - b - b_in. It is the subtract-direction counterpart to the registered 16-bit CLA adder path. Operands are captured on a start handshake and processed one 4-bit slice per cycle through a single lookahead slice, using two's-complement add of ~b with carry = ~b_in. It sits beside the adder in the datapath where area matters more than latency.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of SLICE
SLICE, 4, bits processed per RUN cycle; NSLICE = WIDTH/SLICE (default 4)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (rst==0 at a clk edge resets)
start  in  1  request; sampled only when state is IDLE or DONE
a  in  WIDTH  minuend, captured on accepted start
b  in  WIDTH  subtrahend, captured on accepted start
b_in  in  1  borrow in, captured on accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse: diff/b_out/ovf valid
diff  out  WIDTH  result, held until next result write
b_out  out  1  borrow out (1 = unsigned a < b + b_in)
ovf  out  1  signed overflow of a - b

Behaviour:
- All registered outputs. Reset (rst==0 at an edge): state=IDLE, busy=0, done=0, diff=0, b_out=0, ovf=0, counter=0, operand and carry registers=0.
- States IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
- IDLE/DONE, start==1: capture a_reg=a, nb_reg=~b, carry=~b_in, cnt=0, acc=0; go to RUN.
- IDLE/DONE, start==0: IDLE stays IDLE; DONE goes to IDLE.
- RUN, each edge: slice computes {c, s} = a_reg[SLICE-1:0] + nb_reg[SLICE-1:0] + carry.
  - Set carry=c.
  - Shift a_reg and nb_reg right by SLICE.
  - Insert s into acc from the MSB side (acc = {s, acc[WIDTH-1:SLICE]}); slice 0 ends at the LSBs.
  - cnt++.
- On the edge where cnt==NSLICE-1: write diff=final acc, b_out=~final carry, ovf=(a_sign != b_sign) && (diff[WIDTH-1] != a_sign); go to DONE.
  - a_sign and b_sign are held in dedicated registers captured at start.
- Latency: start sampled at edge k -> busy high from edge k+1 through k+NSLICE; done high for the one cycle after edge k+NSLICE+1 (5 edges at default).
- Back-to-back: start during the DONE cycle is accepted; RUN follows immediately; diff is held until overwritten NSLICE+1 edges later.
- start while RUN: ignored, with no effect on the in-flight operation.
- Operand inputs are don't-care except at the accepting edge.
- Reset mid-RUN: abort immediately to IDLE; no done pulse; diff is cleared to 0.
- Wrap-around is modulo 2^WIDTH, e.g. 0x0000-0x0001 gives 0xFFFF with b_out=1.

Decomposition:
- Shared package sub_pkg holds:
  - WIDTH and SLICE defaults
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
- One sub-module, cla_slice_4: combinational 4-bit carry-lookahead adder.
  - Inputs: x[3:0], y[3:0], ci.
  - Outputs: s[3:0], co.
  - Instantiated once; fed with a_reg and nb_reg LSBs.
- The FSM, counter and shift registers live in sub_16_serial.

Test Plan:
- Reset: hold rst=0 for 2 edges, then rst=1 -> busy=0, done=0, diff=0x0000, b_out=0, ovf=0.
- Basic subtract: a=0x1234, b=0x0234, b_in=0, start 1 cycle -> done 5 edges later; diff=0x1000, b_out=0, ovf=0. busy high exactly 4 cycles.
- Borrow cases:
  - a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, ovf=0.
  - a=0x0005, b=0x0005, b_in=1 -> diff=0xFFFF, b_out=1.
- Signed overflow: a=0x8000, b=0x0001 -> diff=0x7FFF, b_out=0, ovf=1. a=0x7FFF, b=0xFFFF -> diff=0x8000, b_out=1, ovf=1.
- Handshake edges:
  - Start pulsed mid-RUN with different operands -> ignored; the first result is unchanged.
  - Start held during DONE with a=0x00FF, b=0x000F -> second done 5 edges later with diff=0x00F0.
- Reset mid-operation: rst=0 on the 2nd RUN edge -> IDLE, no done pulse, diff=0. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor.
//   WIDTH_DEF : default operand/result width
//   SLICE_DEF : default bits processed per RUN cycle
//   state_e   : controller states
package sub_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned SLICE_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cla_slice_4.sv
// Combinational 4-bit carry-lookahead adder slice.
//   x, y : addend nibbles
//   ci   : carry in
//   s    : sum nibble
//   co   : carry out
module cla_slice_4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   always_comb begin
      p = x ^ y;
      g = x & y;
      // Every carry is computed directly from generate/propagate terms.
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      s    = p ^ c;
   end

endmodule

// File: rtl/sub_16_serial.sv
// Multi-cycle subtractor: diff = a - b - b_in, one SLICE-bit slice per cycle.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active low
//   start : request, accepted in IDLE or DONE
//   a, b  : minuend / subtrahend, captured on accepted start
//   b_in  : borrow in, captured on accepted start
//   busy  : high while operating
//   done  : one-cycle pulse, results valid
//   diff  : result, held until the next result write
//   b_out : borrow out (1 = unsigned a < b + b_in)
//   ovf   : signed overflow
module sub_16_serial
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SLICE = SLICE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             ovf
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_e state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] nb_q, nb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic carry_q, carry_d;
   logic a_sign_q, a_sign_d;
   logic b_sign_q, b_sign_d;
   logic b_out_q, b_out_d;
   logic ovf_q, ovf_d;

   logic [SLICE-1:0] slice_s;
   logic             slice_co;

   // Subtraction is done as a + ~b + ~b_in through the shared adder slice.
   cla_slice_4 u_slice (
      .x  (a_q[SLICE-1:0]),
      .y  (nb_q[SLICE-1:0]),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      nb_d     = nb_q;
      acc_d    = acc_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_sign_d = a_sign_q;
      b_sign_d = b_sign_q;
      b_out_d  = b_out_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d      = a;
               nb_d     = ~b;
               carry_d  = ~b_in;
               cnt_d    = '0;
               acc_d    = '0;
               a_sign_d = a[WIDTH-1];
               b_sign_d = b[WIDTH-1];
               state_d  = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            carry_d = slice_co;
            a_d     = a_q >> SLICE;
            nb_d    = nb_q >> SLICE;
            // Slices enter at the MSB end so slice 0 finishes at the LSBs.
            acc_d   = {slice_s, acc_q[WIDTH-1:SLICE]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NSLICE - 1)) begin
               diff_d  = acc_d;
               b_out_d = ~slice_co;
               ovf_d   = (a_sign_q != b_sign_q) && (acc_d[WIDTH-1] != a_sign_q);
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         nb_q     <= '0;
         acc_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_sign_q <= 1'b0;
         b_sign_q <= 1'b0;
         b_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         nb_q     <= nb_d;
         acc_q    <= acc_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_sign_q <= a_sign_d;
         b_sign_q <= b_sign_d;
         b_out_q  <= b_out_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);
   assign diff  = diff_q;
   assign b_out = b_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_sub_16_serial.sv
// Self-checking bench for sub_16_serial: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_sub_16_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        b_in = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] diff;
   logic        b_out;
   logic        ovf;

   int n_cmp = 0;
   int n_err = 0;

   // Last result the DUT should be holding.
   logic [15:0] exp_diff = '0;
   logic        exp_bo = 1'b0;
   logic        exp_ov = 1'b0;

   sub_16_serial dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (b_out),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer subtraction, borrow = negative result, ovf by sign rule.
   task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                        output logic [15:0] md, output logic mbo, output logic mov);
      int full;
      full = int'({16'h0, ma}) - int'({16'h0, mb}) - int'({31'h0, mbin});
      md   = full[15:0];
      mbo  = (full < 0);
      mov  = (ma[15] != mb[15]) && (md[15] != ma[15]);
   endtask

   // Starts an operation from IDLE or DONE and returns in the DONE cycle.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                        input bit mid);
      logic [15:0] ed;
      logic        eb;
      logic        eo;
      model(ta, tb, tbin, ed, eb, eo);
      a = ta;
      b = tb;
      b_in = tbin;
      start = 1'b1;
      step();
      start = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      b_in = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("diff_hold", diff, exp_diff);
         chk("bout_hold", b_out, exp_bo);
         if (mid) begin
            start = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            b_in = 1'($urandom);
         end
         step();
      end
      start = 1'b0;
      chk("busy_done", busy, 0);
      chk("done_pulse", done, 1);
      chk("diff", diff, ed);
      chk("b_out", b_out, eb);
      chk("ovf", ovf, eo);
      exp_diff = ed;
      exp_bo = eb;
      exp_ov = eo;
   endtask

   task automatic idle();
      start = 1'b0;
      step();
      chk("done_idle", done, 0);
      chk("busy_idle", busy, 0);
      chk("diff_idle", diff, exp_diff);
   endtask

   initial begin
      // Reset
      rst = 1'b0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 16'h0000);
      chk("rst_bout", b_out, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b1;
      idle();

      // Basic and borrow cases
      do_op(16'h1234, 16'h0234, 1'b0, 1'b0);
      chk("lit_basic", diff, 16'h1000);
      idle();
      do_op(16'h0000, 16'h0001, 1'b0, 1'b0);
      chk("lit_wrap", diff, 16'hFFFF);
      chk("lit_wrap_bo", b_out, 1);
      idle();
      do_op(16'h0005, 16'h0005, 1'b1, 1'b0);
      chk("lit_bin", diff, 16'hFFFF);
      chk("lit_bin_bo", b_out, 1);
      idle();

      // Signed overflow, then back-to-back start in the DONE cycle
      do_op(16'h8000, 16'h0001, 1'b0, 1'b0);
      chk("lit_ovf1", diff, 16'h7FFF);
      chk("lit_ovf1_ov", ovf, 1);
      idle();
      do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
      chk("lit_ovf2", diff, 16'h8000);
      chk("lit_ovf2_ov", ovf, 1);
      do_op(16'h00FF, 16'h000F, 1'b0, 1'b0);
      chk("lit_b2b", diff, 16'h00F0);
      idle();

      // Start pulses during RUN must not disturb the operation
      do_op(16'hABCD, 16'h1234, 1'b0, 1'b1);
      chk("lit_mid", diff, 16'h9999);
      idle();

      // Reset on the second RUN edge
      a = 16'h5555;
      b = 16'h1111;
      b_in = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 16'h0000);
      chk("abort_bout", b_out, 0);
      chk("abort_ovf", ovf, 0);
      exp_diff = '0;
      exp_bo = 1'b0;
      exp_ov = 1'b0;
      for (int i = 0; i < 6; i++) idle();
      do_op(16'h4321, 16'h1111, 1'b1, 1'b0);
      chk("lit_after_abort", diff, 16'h320F);
      idle();

      // Random operations, optionally back-to-back and with mid-RUN noise
      for (int n = 0; n < 60; n++) begin
         do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 0) idle();
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
